// File: rtl/cpu_hazard_ctrl.sv
// cpu_hazard_ctrl: decode-stage control and read-after-write hazard unit
// for a 5-step pipeline with no forwarding.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   valid_step_2           step 2 holds a real instruction
//   opcode_step_2          instr[31:26]
//   funct_step_2           instr[5:0] (not needed to tell R-type operands apart)
//   rs/rt/rd_step_2        register fields of the step-2 instruction
//   stall                  freeze steps 1/2 and inject a bubble into step 3
//   valid_step_3           instruction entering step 3 is real
//   control_mux_for_rt_rd  1 = rd is the destination, 0 = rt
//   control_mux_for_wnum   write-number select, tied to 0 (wnum_step_5)
//   is_write_reg           register-file write enable for the step-5 instruction
//   wnum_step_5            destination register of the step-5 instruction
//   stall_count            saturating count of stall cycles
module cpu_hazard_ctrl #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_step_2,
  input  logic [5:0]           opcode_step_2,
  input  logic [5:0]           funct_step_2,
  input  logic [4:0]           rs_step_2,
  input  logic [4:0]           rt_step_2,
  input  logic [4:0]           rd_step_2,
  output logic                 stall,
  output logic                 valid_step_3,
  output logic                 control_mux_for_rt_rd,
  output logic                 control_mux_for_wnum,
  output logic                 is_write_reg,
  output logic [4:0]           wnum_step_5,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned SLOT_N = 3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // In-flight destinations; index 0 = S3, 1 = S4, 2 = S5.
  logic             slot_v   [SLOT_N];
  logic [REG_W-1:0] slot_dst [SLOT_N];

  logic             reads_rs;
  logic             reads_rt;
  logic             writes;
  logic [REG_W-1:0] dst;
  logic             rs_hit;
  logic             rt_hit;

  // Every R-type is treated as rs,rt -> rd, so funct does not affect decode.
  logic funct_unused;
  assign funct_unused = ^funct_step_2;

  // Operand/destination decode of the step-2 instruction.
  always_comb begin
    reads_rs              = 1'b0;
    reads_rt              = 1'b0;
    writes                = 1'b0;
    dst                   = '0;
    control_mux_for_rt_rd = 1'b0;
    unique case (opcode_step_2)
      OP_RTYPE: begin
        reads_rs              = 1'b1;
        reads_rt              = 1'b1;
        writes                = 1'b1;
        dst                   = rd_step_2;
        control_mux_for_rt_rd = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
        reads_rs = 1'b1;
        writes   = 1'b1;
        dst      = rt_step_2;
      end
      OP_SW, OP_BEQ: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      OP_J:    ;
      default: ;
    endcase
  end

  // Source compare against the older in-flight slots only; r0 never hazards.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < SLOT_N; i++) begin
      if (slot_v[i] && (slot_dst[i] == rs_step_2)) rs_hit = 1'b1;
      if (slot_v[i] && (slot_dst[i] == rt_step_2)) rt_hit = 1'b1;
    end
    if (rs_step_2 == '0) rs_hit = 1'b0;
    if (rt_step_2 == '0) rt_hit = 1'b0;
  end

  assign stall = valid_step_2 & ((reads_rs & rs_hit) | (reads_rt & rt_hit));
  assign valid_step_3         = valid_step_2 & ~stall;
  assign control_mux_for_wnum = 1'b0;
  assign is_write_reg         = slot_v[2];
  assign wnum_step_5          = slot_dst[2];

  // Slot table keeps advancing during a stall; a stalled step 2 enters as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOT_N; i++) begin
        slot_v[i]   <= 1'b0;
        slot_dst[i] <= '0;
      end
    end else begin
      slot_v[2]   <= slot_v[1];
      slot_dst[2] <= slot_dst[1];
      slot_v[1]   <= slot_v[0];
      slot_dst[1] <= slot_dst[0];
      slot_v[0]   <= valid_step_2 & writes & (dst != '0) & ~stall;
      slot_dst[0] <= dst;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed bench for cpu_hazard_ctrl: a 16-bit-counter instance and a
// 2-bit-counter instance share one stimulus stream.
module tb_cpu_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_step_2;
  logic [5:0] opcode_step_2;
  logic [5:0] funct_step_2;
  logic [4:0] rs_step_2;
  logic [4:0] rt_step_2;
  logic [4:0] rd_step_2;

  logic        stall, valid_step_3, mux_rt_rd, mux_wnum, is_write_reg;
  logic [4:0]  wnum_step_5;
  logic [15:0] stall_count;

  logic        stall_n, valid_step_3_n, mux_rt_rd_n, mux_wnum_n, is_write_reg_n;
  logic [4:0]  wnum_step_5_n;
  logic [1:0]  stall_count_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_hazard_ctrl #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .valid_step_2(valid_step_2),
    .opcode_step_2(opcode_step_2), .funct_step_2(funct_step_2),
    .rs_step_2(rs_step_2), .rt_step_2(rt_step_2), .rd_step_2(rd_step_2),
    .stall(stall), .valid_step_3(valid_step_3),
    .control_mux_for_rt_rd(mux_rt_rd), .control_mux_for_wnum(mux_wnum),
    .is_write_reg(is_write_reg), .wnum_step_5(wnum_step_5),
    .stall_count(stall_count)
  );

  cpu_hazard_ctrl #(.CNT_WIDTH(2)) dut_narrow (
    .clk(clk), .rst(rst), .valid_step_2(valid_step_2),
    .opcode_step_2(opcode_step_2), .funct_step_2(funct_step_2),
    .rs_step_2(rs_step_2), .rt_step_2(rt_step_2), .rd_step_2(rd_step_2),
    .stall(stall_n), .valid_step_3(valid_step_3_n),
    .control_mux_for_rt_rd(mux_rt_rd_n), .control_mux_for_wnum(mux_wnum_n),
    .is_write_reg(is_write_reg_n), .wnum_step_5(wnum_step_5_n),
    .stall_count(stall_count_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one instruction in step 2 for the next cycle; outputs settle 1 time unit later.
  task automatic cyc(input logic v, input logic [5:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd);
    @(negedge clk);
    valid_step_2  = v;
    opcode_step_2 = op;
    funct_step_2  = 6'h20;
    rs_step_2     = rs;
    rt_step_2     = rt;
    rd_step_2     = rd;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'h00, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    valid_step_2 = 1'b0; opcode_step_2 = '0; funct_step_2 = '0;
    rs_step_2 = '0; rt_step_2 = '0; rd_step_2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall",   stall, 0);
    check("rst_wr",      is_write_reg, 0);
    check("rst_wnum",    wnum_step_5, 0);
    check("rst_cnt",     stall_count, 0);
    check("rst_mux_wn",  mux_wnum, 0);
    check("rst_v3",      valid_step_3, 0);

    // add r3,r1,r2 ; add r4,r3,r1 -> three stall cycles
    cyc(1, 6'h00, 1, 2, 3);
    check("t1_prod_stall", stall, 0);
    check("t1_prod_mux",   mux_rt_rd, 1);
    check("t1_prod_v3",    valid_step_3, 1);
    cyc(1, 6'h00, 3, 1, 4);
    check("t1_s1", stall, 1);
    check("t1_v3", valid_step_3, 0);
    cyc(1, 6'h00, 3, 1, 4);
    check("t1_s2", stall, 1);
    check("t1_s2_wr", is_write_reg, 0);
    cyc(1, 6'h00, 3, 1, 4);
    check("t1_s3", stall, 1);
    check("t1_s3_wr",   is_write_reg, 1);
    check("t1_s3_wnum", wnum_step_5, 3);
    cyc(1, 6'h00, 3, 1, 4);
    check("t1_release", stall, 0);
    check("t1_cnt",     stall_count, 3);
    idle(4);

    // lw r5,0(r1) ; ori r6,r2,1 ; sw r5,4(r1) -> two stalls on sw
    cyc(1, 6'h23, 1, 5, 0);
    check("t2_lw_stall", stall, 0);
    check("t2_lw_mux",   mux_rt_rd, 0);
    cyc(1, 6'h0D, 2, 6, 0);
    check("t2_ori_stall", stall, 0);
    check("t2_ori_mux",   mux_rt_rd, 0);
    cyc(1, 6'h2B, 1, 5, 0);
    check("t2_sw_s1",  stall, 1);
    check("t2_sw_mux", mux_rt_rd, 0);
    cyc(1, 6'h2B, 1, 5, 0);
    check("t2_sw_s2",   stall, 1);
    check("t2_lw_wr",   is_write_reg, 1);
    check("t2_lw_wnum", wnum_step_5, 5);
    cyc(1, 6'h2B, 1, 5, 0);
    check("t2_release", stall, 0);
    check("t2_cnt_wide",   stall_count, 5);
    check("t2_cnt_narrow", stall_count_n, 3);
    idle(4);

    // addi r0,r1,5 ; add r2,r0,r0 -> no stall, r0 write suppressed
    cyc(1, 6'h08, 1, 0, 0);
    check("t3_addi_stall", stall, 0);
    cyc(1, 6'h00, 0, 0, 2);
    check("t3_add_stall", stall, 0);
    idle(1);
    idle(1);
    check("t3_addi_wr", is_write_reg, 0);
    idle(1);
    check("t3_add_wr",   is_write_reg, 1);
    check("t3_add_wnum", wnum_step_5, 2);
    idle(4);

    // add r7 ; opcode 3F ; j -> only add r7 retires
    cyc(1, 6'h00, 1, 2, 7);
    cyc(1, 6'h3F, 7, 7, 7);
    check("t5_unk_stall", stall, 0);
    cyc(1, 6'h02, 7, 7, 7);
    check("t5_j_stall", stall, 0);
    idle(1);
    check("t5_add_wr",   is_write_reg, 1);
    check("t5_add_wnum", wnum_step_5, 7);
    idle(1);
    check("t5_unk_wr", is_write_reg, 0);
    idle(1);
    check("t5_j_wr", is_write_reg, 0);
    check("t5_cnt",  stall_count, 5);

    // valid_step_2 = 0 with a would-be hazard never stalls
    cyc(1, 6'h00, 1, 2, 9);
    cyc(0, 6'h00, 9, 9, 1);
    check("t6_invalid_stall", stall, 0);
    idle(4);

    // Reset in the 2nd cycle of a 3-cycle stall
    cyc(1, 6'h00, 1, 2, 3);
    cyc(1, 6'h00, 3, 1, 4);
    check("t4_s1", stall, 1);
    cyc(1, 6'h00, 3, 1, 4);
    check("t4_s2", stall, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t4_stall",      stall, 0);
    check("t4_wr",         is_write_reg, 0);
    check("t4_cnt",        stall_count, 0);
    check("t4_cnt_narrow", stall_count_n, 0);
    check("t4_v3",         valid_step_3, 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_hazard_ctrl.md
Name: cpu_hazard_ctrl

Overview:
- Control and hazard unit for the decode stage (step 2) of the 5-step pipeline.
- Decodes opcode/funct from step 2 and drives the decode-stage control inputs: is_write_reg, control_mux_for_rt_rd, control_mux_for_wnum.
- Tracks in-flight register destinations in steps 3–5 and stalls steps 1–2 on read-after-write hazards; no forwarding exists.
- Supplies the write-back register number (wnum_step_5) and counts stall cycles.

Parameters:
- CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- valid_step_2  input  1  step 2 holds a real instruction
- opcode_step_2  input  6  instr[31:26]
- funct_step_2  input  6  instr[5:0]
- rs_step_2  input  5  instr[25:21]
- rt_step_2  input  5  instr[20:16]
- rd_step_2  input  5  instr[15:11]
- stall  output  1  freeze step 1/2 registers; inject a bubble into step 3
- valid_step_3  output  1  instruction entering step 3 is real (0 = bubble)
- control_mux_for_rt_rd  output  1  1 = rd is destination, 0 = rt
- control_mux_for_wnum  output  1  write-number select; constant 0 = wnum_step_5
- is_write_reg  output  1  register-file write enable for the step-5 instruction
- wnum_step_5  output  5  destination register of the step-5 instruction
- stall_count  output  CNT_WIDTH  saturating count of stall cycles

Behaviour:
- Reset is synchronous, active-high, clk-edge only. On reset:
  - all in-flight slots are invalid, with dst = 0;
  - stall_count = 0;
  - is_write_reg = 0, wnum_step_5 = 0, stall = 0;
  - control_mux_for_wnum = 0.
- Decode is combinational on the step-2 inputs:
  - opcode 0x00 (R-type): reads rs, rt; writes rd; control_mux_for_rt_rd = 1.
  - addi 0x08, andi 0x0C, ori 0x0D, lw 0x23: read rs; write rt.
  - sw 0x2B, beq 0x04: read rs, rt; no write.
  - j 0x02: no reads, no write.
  - Any other opcode: NOP (no reads, no write).
  - control_mux_for_rt_rd = 0 for every non-R-type opcode.
  - A destination of register 0 counts as "no write".
- In-flight table: three slots S3, S4, S5, each holding {v, dst}. Updated every clock edge:
  - S5 <= S4, S4 <= S3.
  - S3 <= {valid_step_2 & writes & !stall, dst}.
  - The table advances during a stall; only steps 1–2 hold.
- Hazard rule:
  - stall = valid_step_2 & (src matches the dst of any valid slot S3, S4 or S5), over every used source register that is nonzero.
  - The register file has no write-through, so a match in S5 also stalls.
  - Stall duration is therefore 1–3 cycles; it releases automatically as the producer retires.
- valid_step_3 = valid_step_2 & !stall.
- Write-back outputs:
  - is_write_reg = S5.v
  - wnum_step_5 = S5.dst
- control_mux_for_wnum is tied to 0.
- stall_count increments by 1 on each clock where stall = 1 and holds at all-ones; it never wraps.
- Simultaneous events:
  - If the step-2 instruction writes the same register it reads (e.g. add r3,r3,r1), the read is checked only against the older slots.
  - A new write to a register already in flight just adds another slot entry; there is no merging.
- Reset mid-stall: all slots clear on that edge, so stall drops to 0 in the following cycle.
- valid_step_2 = 0: never stalls and inserts no slot entry.

Test Plan:
- Dependent pair, no gap: add r3,r1,r2 then add r4,r3,r1 -> stall = 1 for exactly 3 cycles; is_write_reg = 1 with wnum_step_5 = 3 on the 3rd stall cycle; stall_count = 3.
- One independent instruction between producer and consumer (lw r5,0(r1); ori r6,r2,1; sw r5,4(r1)) -> 2 stall cycles on the sw; the ori never stalls; control_mux_for_rt_rd = 0 throughout.
- Write to r0 (addi r0,r1,5) followed by add r2,r0,r0 -> no stall; is_write_reg stays 0 for the addi.
- Reset asserted during the 2nd cycle of a 3-cycle stall -> next cycle stall = 0, is_write_reg = 0, stall_count = 0.
- Unknown opcode 0x3F and j 0x02 back-to-back behind add r7 -> no stalls and no slot entries; only add r7 reaches step 5 (is_write_reg = 1, wnum = 7).
- With CNT_WIDTH = 2, force 5 stall cycles -> stall_count holds at 3 and does not wrap.
